alu_mc: RTL and testbench
=========================

ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning datapath width; legal values are powers of two, 4 to 64.
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port in_valid  input  1  operation request.
REQ-005 SHALL have port in_ready  output  1  block can accept a request.
REQ-006 SHALL have port opcode  input  4  operation select, per REQ-012.
REQ-007 SHALL have ports a and b  input  WIDTH each  operands.
REQ-008 SHALL have port out_valid  output  1  result available.
REQ-009 SHALL have port out_ready  input  1  consumer takes the result.
REQ-010 SHALL have port result  output  WIDTH  operation result.
REQ-011 SHALL have ports zero, carry and illegal  output  1 each  flags, per REQ-017 to REQ-019.

Function
REQ-012 Opcodes SHALL be: 0 XOR; 1 BEQ; 2 ADD; 3 AND; 4 ROL; 5 ROR; 6 SUB; 7 MUL; 8-15 illegal.
REQ-013 The FSM SHALL have three states: IDLE, BUSY and DONE.
REQ-014 Transitions SHALL be as follows:
- IDLE to BUSY on accept of ROL or ROR with a nonzero count, or of MUL.
- IDLE to DONE on accept of any other request.
- BUSY to DONE when the iteration count expires.
- DONE to IDLE when out_ready=1.
REQ-015 Accept SHALL be in_valid and in_ready on a rising edge; a, b and opcode are captured only at accept.
REQ-016 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE; there is no overlap of operations.
REQ-017 zero SHALL equal 1 exactly when result is all zeros; it is computed from the final result.
REQ-018 carry SHALL carry the following value:
- ADD: carry-out of bit WIDTH-1.
- SUB: borrow, i.e. a<b unsigned.
- MUL: 1 if the upper WIDTH bits of the 2*WIDTH product are nonzero.
- All other opcodes: 0.
REQ-019 illegal SHALL be 1 only for opcodes 8-15; in that case result is all ones and carry is 0.
REQ-020 Single-cycle ops (XOR, BEQ, ADD, AND, SUB, illegal) SHALL assert out_valid in the cycle after accept, i.e. latency 1.
REQ-021 BEQ SHALL give result 0 if a==b, else 1 (zero-extended).
REQ-022 ROL and ROR SHALL use n = b mod WIDTH, taken from the low log2(WIDTH) bits of b.
REQ-023 ROL and ROR SHALL rotate one bit per BUSY cycle, so latency is n+1; n=0 gives result a with latency 1.
REQ-024 MUL SHALL be unsigned shift-add, one bit of b per BUSY cycle, so latency is WIDTH+1.
REQ-025 MUL result SHALL be the low WIDTH bits of the product.
REQ-026 While in DONE with out_ready=0, result and all flags SHALL be held stable for any number of cycles.
REQ-027 in_valid during BUSY or DONE SHALL be ignored; the request is not lost, since in_ready=0 signals the requester to hold.
REQ-028 Back-to-back operation: when DONE and out_ready=1, the block SHALL be in IDLE next cycle with in_ready=1, giving a minimum issue interval of 2 cycles.

Reset
REQ-029 While rst_n=0 at a clock edge, the next state SHALL be as follows:
- state IDLE;
- in_ready 1 (after reset);
- out_valid 0;
- result 0;
- zero, carry and illegal all 0;
- iteration counter 0.
REQ-030 Reset asserted in BUSY or DONE SHALL abort the operation; no out_valid is produced for the aborted request.

Structure
REQ-031 Package alu_mc_pkg SHALL hold:
- the opcode enum (4-bit);
- the FSM state enum;
- localparams for the opcode encodings.
REQ-032 Sub-module alu_mc_iter SHALL hold the iterative ROL/ROR/MUL datapath: shift register, accumulator and down-counter with start/done ports.
REQ-033 The single-cycle ops and the FSM SHALL stay in alu_mc.

Verification (WIDTH=8)
REQ-034 ADD a=F0h, b=20h -> result 10h, carry 1, zero 0; out_valid 1 cycle after accept.
REQ-035 ROL a=81h, b=03h -> result 0Ch after 4 cycles; ROR a=81h, b=0Bh (n=3) -> result 30h after 4 cycles.
REQ-036 MUL 0Dh*0Bh -> result 8Fh, carry 0; MUL 14h*14h -> result 90h, carry 1; each after 9 cycles.
REQ-037 Hold out_ready=0 for 3 cycles after SUB a=05h, b=07h:
- result stays FEh for all 3 cycles;
- carry stays 1;
- in_ready stays 0;
- in_valid pulses during the hold are not accepted.
REQ-038 rst_n=0 in the 4th BUSY cycle of MUL -> next cycle in IDLE, out_valid 0, in_ready 1, result 00h; no result is ever delivered for the aborted op.
REQ-039 Opcode Fh -> result FFh, illegal 1. BEQ a=b=5Ah -> result 00h, zero 1, illegal 0.

Source files
------------

// File: rtl/alu_mc_pkg.sv
// alu_mc_pkg: shared types for the multi-cycle ALU.
//   - opcode encodings (localparams) and the matching 4-bit opcode enum
//   - FSM state enum used by alu_mc
package alu_mc_pkg;

  localparam logic [3:0] OpcXor = 4'h0;
  localparam logic [3:0] OpcBeq = 4'h1;
  localparam logic [3:0] OpcAdd = 4'h2;
  localparam logic [3:0] OpcAnd = 4'h3;
  localparam logic [3:0] OpcRol = 4'h4;
  localparam logic [3:0] OpcRor = 4'h5;
  localparam logic [3:0] OpcSub = 4'h6;
  localparam logic [3:0] OpcMul = 4'h7;

  // Encodings 8..15 are not members and are treated as illegal.
  typedef enum logic [3:0] {
    OpXor = OpcXor,
    OpBeq = OpcBeq,
    OpAdd = OpcAdd,
    OpAnd = OpcAnd,
    OpRol = OpcRol,
    OpRor = OpcRor,
    OpSub = OpcSub,
    OpMul = OpcMul
  } opcode_e;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StDone
  } state_e;

endpackage

// File: rtl/alu_mc_iter.sv
// alu_mc_iter: iterative datapath for ROL, ROR (one bit per cycle) and MUL (unsigned
// shift-add, one multiplier bit per cycle).
// Ports:
//   clk_i, rst_ni  clock and synchronous active-low reset
//   start_i        load operands and iteration count (count must be nonzero)
//   op_i           OpRol, OpRor or OpMul
//   a_i, b_i       operands; rotate count is b_i mod Width
//   done_o         high in the last iteration cycle
//   result_o       value the datapath holds after the current step (valid with done_o)
//   carry_o        MUL overflow flag, same timing as result_o
module alu_mc_iter
  import alu_mc_pkg::*;
#(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  opcode_e          op_i,
  input  logic [Width-1:0] a_i,
  input  logic [Width-1:0] b_i,
  output logic             done_o,
  output logic [Width-1:0] result_o,
  output logic             carry_o
);

  localparam int unsigned ShW  = $clog2(Width);
  localparam int unsigned CntW = $clog2(Width) + 1;

  opcode_e            op_q, op_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [Width-1:0]   sr_q, sr_d;       // rotate data, or multiplier for MUL
  logic [2*Width-1:0] mcand_q, mcand_d;
  logic [2*Width-1:0] acc_q, acc_d;

  always_comb begin
    op_d    = op_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    mcand_d = mcand_q;
    acc_d   = acc_q;
    if (start_i) begin
      op_d    = op_i;
      sr_d    = (op_i == OpMul) ? b_i : a_i;
      mcand_d = {{Width{1'b0}}, a_i};
      acc_d   = '0;
      cnt_d   = (op_i == OpMul) ? CntW'(Width) : CntW'(b_i[ShW-1:0]);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CntW'(1);
      case (op_q)
        OpRol: sr_d = {sr_q[Width-2:0], sr_q[Width-1]};
        OpRor: sr_d = {sr_q[0], sr_q[Width-1:1]};
        OpMul: begin
          acc_d   = acc_q + (sr_q[0] ? mcand_q : '0);
          sr_d    = sr_q >> 1;
          mcand_d = mcand_q << 1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      op_q    <= OpXor;
      cnt_q   <= '0;
      sr_q    <= '0;
      mcand_q <= '0;
      acc_q   <= '0;
    end else begin
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      mcand_q <= mcand_d;
      acc_q   <= acc_d;
    end
  end

  // Outputs look at the post-step value so the parent can capture them on the
  // same edge that performs the final iteration.
  assign done_o   = (cnt_q == CntW'(1));
  assign result_o = (op_q == OpMul) ? acc_d[Width-1:0] : sr_d;
  assign carry_o  = (op_q == OpMul) && (|acc_d[2*Width-1:Width]);

endmodule

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU with valid/ready handshake on both sides.
// Ports:
//   clk, rst_n           clock and synchronous active-low reset
//   in_valid, in_ready   request handshake; in_ready only in IDLE
//   opcode, a, b         operation and operands, captured at accept
//   out_valid, out_ready result handshake; out_valid only in DONE
//   result, zero, carry, illegal  registered result and flags, stable while DONE
module alu_mc
  import alu_mc_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry,
  output logic             illegal
);

  localparam int unsigned ShW = $clog2(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] result_q;
  logic             zero_q, carry_q, illegal_q;

  logic             accept, goes_busy, is_rot;
  logic [WIDTH-1:0] sc_result;
  logic             sc_carry, sc_illegal;
  logic             iter_done, iter_carry;
  logic [WIDTH-1:0] iter_result;

  assign accept    = in_valid && in_ready;
  assign is_rot    = (opcode == OpcRol) || (opcode == OpcRor);
  assign goes_busy = (is_rot && (b[ShW-1:0] != '0)) || (opcode == OpcMul);

  // Single-cycle results, including zero-count rotates.
  always_comb begin
    sc_result  = '0;
    sc_carry   = 1'b0;
    sc_illegal = 1'b0;
    case (opcode)
      OpcXor:         sc_result = a ^ b;
      OpcBeq:         sc_result = (a == b) ? '0 : WIDTH'(1);
      OpcAdd:         {sc_carry, sc_result} = {1'b0, a} + {1'b0, b};
      OpcAnd:         sc_result = a & b;
      OpcRol, OpcRor: sc_result = a;
      OpcSub: begin
        sc_result = a - b;
        sc_carry  = (a < b);
      end
      OpcMul:         sc_result = '0;
      default: begin
        sc_result  = '1;
        sc_illegal = 1'b1;
      end
    endcase
  end

  alu_mc_iter #(
    .Width(WIDTH)
  ) u_iter (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .start_i (accept && goes_busy),
    .op_i    (opcode_e'(opcode)),
    .a_i     (a),
    .b_i     (b),
    .done_o  (iter_done),
    .result_o(iter_result),
    .carry_o (iter_carry)
  );

  // FSM: state register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = goes_busy ? StBusy : StDone;
      StBusy:  if (iter_done) state_d = StDone;
      StDone:  if (out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM: outputs
  always_comb begin
    in_ready  = (state_q == StIdle);
    out_valid = (state_q == StDone);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      result_q  <= '0;
      zero_q    <= 1'b0;
      carry_q   <= 1'b0;
      illegal_q <= 1'b0;
    end else if (accept && !goes_busy) begin
      result_q  <= sc_result;
      zero_q    <= (sc_result == '0);
      carry_q   <= sc_carry;
      illegal_q <= sc_illegal;
    end else if ((state_q == StBusy) && iter_done) begin
      result_q  <= iter_result;
      zero_q    <= (iter_result == '0);
      carry_q   <= iter_carry;
      illegal_q <= 1'b0;
    end
  end

  assign result  = result_q;
  assign zero    = zero_q;
  assign carry   = carry_q;
  assign illegal = illegal_q;

endmodule

// File: tb/tb_alu_mc.sv
module tb_alu_mc;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] opcode;
  logic [7:0] a, b;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] result;
  logic       zero, carry, illegal;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_mc #(
    .WIDTH(8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .opcode   (opcode),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .zero     (zero),
    .carry    (carry),
    .illegal  (illegal)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issue one op, scramble inputs after accept, measure latency, check outputs, release.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [7:0] ai,
                        input logic [7:0] bi, input int exp_lat, input logic [7:0] exp_res,
                        input logic exp_c, input logic exp_z, input logic exp_ill);
    int lat;
    @(negedge clk);
    check({tag, " in_ready"}, in_ready, 1);
    opcode   = op;
    a        = ai;
    b        = bi;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    a        = ~ai;
    b        = ~bi;
    opcode   = ~op;
    lat      = 1;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " result"}, result, exp_res);
    check({tag, " carry"}, carry, exp_c);
    check({tag, " zero"}, zero, exp_z);
    check({tag, " illegal"}, illegal, exp_ill);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, " idle after release"}, {in_ready, out_valid}, 2'b10);
  endtask

  initial begin
    int lat;
    int seen;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    opcode    = 4'h0;
    a         = 8'h00;
    b         = 8'h00;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check("reset in_ready", in_ready, 1);
    check("reset out_valid", out_valid, 0);
    check("reset result", result, 8'h00);
    check("reset flags", {zero, carry, illegal}, 3'b000);

    //     tag           op     a      b      lat res    c  z  ill
    run_op("add_f0_20",  4'h2, 8'hF0, 8'h20, 1, 8'h10, 1, 0, 0);
    run_op("add_ff_01",  4'h2, 8'hFF, 8'h01, 1, 8'h00, 1, 1, 0);
    run_op("rol_81_3",   4'h4, 8'h81, 8'h03, 4, 8'h0C, 0, 0, 0);
    run_op("ror_81_b",   4'h5, 8'h81, 8'h0B, 4, 8'h30, 0, 0, 0);
    run_op("rol_n0",     4'h4, 8'hA5, 8'h08, 1, 8'hA5, 0, 0, 0);
    run_op("ror_81_7",   4'h5, 8'h81, 8'h07, 8, 8'h03, 0, 0, 0);
    run_op("mul_0d_0b",  4'h7, 8'h0D, 8'h0B, 9, 8'h8F, 0, 0, 0);
    run_op("mul_14_14",  4'h7, 8'h14, 8'h14, 9, 8'h90, 1, 0, 0);
    run_op("mul_00_ff",  4'h7, 8'h00, 8'hFF, 9, 8'h00, 0, 1, 0);
    run_op("illegal_f",  4'hF, 8'h12, 8'h34, 1, 8'hFF, 0, 0, 1);
    run_op("illegal_8",  4'h8, 8'h00, 8'h00, 1, 8'hFF, 0, 0, 1);
    run_op("beq_eq",     4'h1, 8'h5A, 8'h5A, 1, 8'h00, 0, 1, 0);
    run_op("beq_ne",     4'h1, 8'h5A, 8'h5B, 1, 8'h01, 0, 0, 0);
    run_op("xor",        4'h0, 8'h3C, 8'h0F, 1, 8'h33, 0, 0, 0);
    run_op("and",        4'h3, 8'h3C, 8'h0F, 1, 8'h0C, 0, 0, 0);
    run_op("sub_07_05",  4'h6, 8'h07, 8'h05, 1, 8'h02, 0, 0, 0);

    // Hold the SUB result with out_ready low while other requests are offered.
    @(negedge clk);
    opcode   = 4'h6;
    a        = 8'h05;
    b        = 8'h07;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check("hold out_valid", out_valid, 1);
    for (int i = 0; i < 3; i++) begin
      opcode   = 4'h2;
      a        = 8'h01;
      b        = 8'h01;
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      check("hold result", result, 8'hFE);
      check("hold carry", carry, 1);
      check("hold in_ready", in_ready, 0);
      check("hold out_valid", out_valid, 1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("hold release idle", {in_ready, out_valid}, 2'b10);
    check("hold pulses ignored", result, 8'hFE);

    // Reset in the 4th BUSY cycle of MUL aborts the operation.
    @(negedge clk);
    opcode   = 4'h7;
    a        = 8'h0D;
    b        = 8'h0B;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("abort in_ready", in_ready, 1);
    check("abort out_valid", out_valid, 0);
    check("abort result", result, 8'h00);
    check("abort flags", {zero, carry, illegal}, 3'b000);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("abort no delivery", seen, 0);

    // Clean op after abort to confirm the datapath restarts properly.
    run_op("mul_after_abort", 4'h7, 8'h03, 8'h05, 9, 8'h0F, 0, 0, 0);

    lat = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
